// File: rtl/am2940_pkg.sv
// Shared types and constants for the Am2940-style control decoder slice.
package am2940_pkg;

    localparam int unsigned INSTR_W = 3;
    localparam int unsigned CR_W    = 3;
    localparam int unsigned MODE_W  = 2;
    localparam int unsigned CR_DIR  = 2;

    typedef enum logic [INSTR_W-1:0] {
        I_WRCR   = 3'b000,
        I_RDCR   = 3'b001,
        I_RDWC   = 3'b010,
        I_RDAC   = 3'b011,
        I_REINIT = 3'b100,
        I_LDADDR = 3'b101,
        I_LDWC   = 3'b110,
        I_ENCT   = 3'b111
    } instr_e;

    typedef enum logic [MODE_W-1:0] {
        M_WC_DOWN = 2'b00,
        M_WC_UP   = 2'b01,
        M_AC_CMP  = 2'b10,
        M_WRAP    = 2'b11
    } mode_e;

    typedef enum logic [1:0] {
        S_IDLE  = 2'b00,
        S_READY = 2'b01,
        S_RUN   = 2'b10,
        S_DONE  = 2'b11
    } state_e;

    typedef struct packed {
        logic plwr;
        logic plwc;
        logic selw;
        logic enw;
        logic incw;
        logic wci;
        logic plar;
        logic plac;
        logic sela;
        logic ena;
        logic inca;
        logic aci;
    } strobe_t;

    // Instructions that (re)configure a transfer and return it to READY.
    function automatic logic is_setup(input instr_e op);
        return (op == I_WRCR) || (op == I_LDADDR) || (op == I_LDWC) || (op == I_REINIT);
    endfunction

endpackage

// File: rtl/am2940_control_decoder_if.sv
// Instruction/bus/strobe bundle between the control decoder and its neighbours.
interface am2940_control_decoder_if #(parameter int unsigned W = 4);
    import am2940_pkg::*;

    logic [INSTR_W-1:0] instr;
    logic [W-1:0]       data_in;
    logic               cin;
    logic [W-1:0]       word_count_in;
    logic [W-1:0]       word_reg_in;
    logic [W-1:0]       addr_count_in;
    logic               plwr, plwc, selw, enw, incw, wci;
    logic               plar, plac, sela, ena, inca, aci;
    logic [W-1:0]       data_out;
    logic               data_oe;
    logic               done;
    logic [CR_W-1:0]    ctrl_reg;

    modport master (
        output instr, data_in, cin, word_count_in, word_reg_in, addr_count_in,
        input  plwr, plwc, selw, enw, incw, wci, plar, plac, sela, ena, inca, aci,
        input  data_out, data_oe, done, ctrl_reg
    );

    modport slave (
        input  instr, data_in, cin, word_count_in, word_reg_in, addr_count_in,
        output plwr, plwc, selw, enw, incw, wci, plar, plac, sela, ena, inca, aci,
        output data_out, data_oe, done, ctrl_reg
    );
endinterface

// File: rtl/am2940_done_detect.sv
// Terminal-count compare on pre-count values, selected by transfer mode.
module am2940_done_detect
    import am2940_pkg::*;
#(
    parameter int unsigned W = 4
) (
    input  mode_e        mode,
    input  logic [W-1:0] wc,
    input  logic [W-1:0] wr,
    input  logic [W-1:0] ac,
    input  logic         inca,
    output logic         term
);

    logic [W-1:0] ac_next;

    always_comb begin
        ac_next = inca ? (ac + W'(1)) : (ac - W'(1));
        term    = 1'b0;
        case (mode)
            M_WC_DOWN: term = (wc == W'(1));
            M_WC_UP:   term = (wc == (wr - W'(1)));
            M_AC_CMP:  term = (ac_next == wr);
            default:   term = 1'b0;
        endcase
    end

endmodule

// File: rtl/am2940_control_decoder.sv
// Am2940 control stage: instruction decode, control register, transfer FSM,
// word/address strobes and registered read-back.
module am2940_control_decoder
    import am2940_pkg::*;
#(
    parameter int unsigned W = 4
) (
    input logic                     clk,
    input logic                     res_n,
    am2940_control_decoder_if.slave bus
);

    state_e          state, state_nx;
    logic            a_ok, w_ok, a_ok_nx, w_ok_nx;
    logic            done_q;
    logic [CR_W-1:0] cr;
    logic [W-1:0]    data_q;
    logic            oe_q;
    instr_e          op;
    mode_e           mode;
    logic            inca_dir;
    logic            counting;
    logic            term;
    strobe_t         strb;
    logic            unused_din_hi;

    assign op            = instr_e'(bus.instr);
    assign mode          = mode_e'(cr[MODE_W-1:0]);
    assign inca_dir      = ~cr[CR_DIR];
    assign counting      = ((state == S_READY) || (state == S_RUN)) && (op == I_ENCT) && bus.cin;
    assign unused_din_hi = ^bus.data_in[W-1:CR_W];

    am2940_done_detect #(.W(W)) u_done_detect (
        .mode (mode),
        .wc   (bus.word_count_in),
        .wr   (bus.word_reg_in),
        .ac   (bus.addr_count_in),
        .inca (inca_dir),
        .term (term)
    );

    // State register
    always_ff @(posedge clk or negedge res_n) begin
        if (!res_n) begin
            state  <= S_IDLE;
            a_ok   <= 1'b0;
            w_ok   <= 1'b0;
            done_q <= 1'b0;
        end else begin
            state  <= state_nx;
            a_ok   <= a_ok_nx;
            w_ok   <= w_ok_nx;
            done_q <= (state_nx == S_DONE);
        end
    end

    // Next-state logic
    always_comb begin
        state_nx = state;
        a_ok_nx  = a_ok;
        w_ok_nx  = w_ok;
        case (state)
            S_IDLE: begin
                if (op == I_LDADDR) a_ok_nx = 1'b1;
                if (op == I_LDWC)   w_ok_nx = 1'b1;
                if ((op == I_REINIT) || (a_ok_nx && w_ok_nx)) state_nx = S_READY;
            end
            S_READY, S_RUN: begin
                if (counting)          state_nx = term ? S_DONE : S_RUN;
                else if (is_setup(op)) state_nx = S_READY;
            end
            S_DONE: begin
                if (is_setup(op)) state_nx = S_READY;
            end
            default: state_nx = S_IDLE;
        endcase
    end

    // Strobe outputs; held quiet while reset is asserted
    always_comb begin
        strb = '0;
        if (res_n) begin
            case (op)
                I_REINIT: begin
                    strb.plwc = 1'b1;
                    strb.plac = 1'b1;
                    strb.selw = 1'b1;
                    strb.sela = 1'b1;
                end
                I_LDADDR: begin
                    strb.plar = 1'b1;
                    strb.plac = 1'b1;
                end
                I_LDWC: begin
                    strb.plwr = 1'b1;
                    strb.plwc = 1'b1;
                end
                I_ENCT: begin
                    if (counting) begin
                        strb.wci  = bus.cin;
                        strb.aci  = bus.cin;
                        strb.ena  = 1'b1;
                        strb.inca = inca_dir;
                        case (mode)
                            M_WC_UP:  begin strb.enw = 1'b1; strb.incw = 1'b1; end
                            M_AC_CMP: strb.enw = 1'b0;
                            default:  strb.enw = 1'b1;
                        endcase
                    end
                end
                default: ;
            endcase
        end
    end

    // Control register and read-back path
    always_ff @(posedge clk or negedge res_n) begin
        if (!res_n) begin
            cr     <= '0;
            data_q <= '0;
            oe_q   <= 1'b0;
        end else begin
            oe_q <= (op == I_RDCR) || (op == I_RDWC) || (op == I_RDAC);
            case (op)
                I_WRCR: cr     <= bus.data_in[CR_W-1:0];
                I_RDCR: data_q <= W'(cr);
                I_RDWC: data_q <= bus.word_count_in;
                I_RDAC: data_q <= bus.addr_count_in;
                default: ;
            endcase
        end
    end

    assign bus.plwr     = strb.plwr;
    assign bus.plwc     = strb.plwc;
    assign bus.selw     = strb.selw;
    assign bus.enw      = strb.enw;
    assign bus.incw     = strb.incw;
    assign bus.wci      = strb.wci;
    assign bus.plar     = strb.plar;
    assign bus.plac     = strb.plac;
    assign bus.sela     = strb.sela;
    assign bus.ena      = strb.ena;
    assign bus.inca     = strb.inca;
    assign bus.aci      = strb.aci;
    assign bus.data_out = data_q;
    assign bus.data_oe  = oe_q;
    assign bus.done     = done_q;
    assign bus.ctrl_reg = cr;

endmodule

// File: tb/tb_am2940_control_decoder.sv
// Directed-vector bench for the Am2940 control decoder.
module tb_am2940_control_decoder;
    import am2940_pkg::*;

    localparam int unsigned W = 4;

    logic clk;
    logic res_n;
    int   n_vec;
    int   n_err;

    am2940_control_decoder_if #(.W(W)) bus ();

    am2940_control_decoder #(.W(W)) dut (
        .clk   (clk),
        .res_n (res_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_vec++;
        assert (obs === exp)
        else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Apply one instruction at the falling edge; comb strobes are stable 1 time unit later.
    task automatic drive(input logic [2:0] i, input logic c, input logic [W-1:0] din,
                         input logic [W-1:0] wc, input logic [W-1:0] wr, input logic [W-1:0] ac);
        @(negedge clk);
        bus.instr         = i;
        bus.cin           = c;
        bus.data_in       = din;
        bus.word_count_in = wc;
        bus.word_reg_in   = wr;
        bus.addr_count_in = ac;
        #1;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        n_vec = 0;
        n_err = 0;
        res_n = 1'b0;
        bus.instr = I_ENCT; bus.cin = 1'b1; bus.data_in = '0;
        bus.word_count_in = '0; bus.word_reg_in = '0; bus.addr_count_in = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_enw", 8'(bus.enw), 8'h0);
        chk("rst_done", 8'(bus.done), 8'h0);
        chk("rst_cr", 8'(bus.ctrl_reg), 8'h0);
        chk("rst_dout", 8'(bus.data_out), 8'h0);
        chk("rst_oe", 8'(bus.data_oe), 8'h0);
        @(negedge clk);
        res_n = 1'b1;

        // IDLE ignores ENCT
        drive(I_ENCT, 1'b1, 4'h0, 4'h6, 4'h6, 4'h3);
        chk("idle_enw", 8'(bus.enw), 8'h0);
        chk("idle_ena", 8'(bus.ena), 8'h0);
        tick();

        drive(I_LDADDR, 1'b0, 4'h3, 4'h0, 4'h0, 4'h0);
        chk("ldaddr_strb", 8'({bus.plar, bus.plac, bus.sela}), 8'b110);
        tick();
        drive(I_LDWC, 1'b0, 4'h6, 4'h0, 4'h0, 4'h3);
        chk("ldwc_strb", 8'({bus.plwr, bus.plwc, bus.selw}), 8'b110);
        tick();

        drive(I_WRCR, 1'b0, 4'h0, 4'h6, 4'h6, 4'h3);
        tick();

        // Mode 00: count 6 down to 0, done on the 6th edge
        for (int i = 0; i < 6; i++) begin
            drive(I_ENCT, 1'b1, 4'h0, W'(6 - i), 4'h6, W'(3 + i));
            chk("m00_strb", 8'({bus.enw, bus.incw, bus.wci, bus.ena, bus.inca, bus.aci}), 8'b101111);
            tick();
            chk("m00_done", 8'(bus.done), (i == 5) ? 8'h1 : 8'h0);
        end
        drive(I_ENCT, 1'b1, 4'h0, 4'h0, 4'h6, 4'h9);
        chk("m00_after_enw", 8'(bus.enw), 8'h0);
        chk("m00_after_ena", 8'(bus.ena), 8'h0);
        tick();
        chk("m00_hold_done", 8'(bus.done), 8'h1);

        // Read-back: one-cycle data_oe pulse
        drive(I_RDWC, 1'b0, 4'h0, 4'h9, 4'h6, 4'h9);
        chk("rdwc_oe_pre", 8'(bus.data_oe), 8'h0);
        tick();
        chk("rdwc_data", 8'(bus.data_out), 8'h9);
        chk("rdwc_oe", 8'(bus.data_oe), 8'h1);
        drive(I_ENCT, 1'b0, 4'h0, 4'h9, 4'h6, 4'h9);
        tick();
        chk("rdwc_oe_drop", 8'(bus.data_oe), 8'h0);
        chk("rdwc_done_kept", 8'(bus.done), 8'h1);

        drive(I_REINIT, 1'b0, 4'h0, 4'h9, 4'h6, 4'h9);
        chk("reinit_strb", 8'({bus.plwc, bus.plac, bus.selw, bus.sela}), 8'b1111);
        tick();
        chk("reinit_done", 8'(bus.done), 8'h0);

        // CR write visible only after the edge
        drive(I_WRCR, 1'b0, 4'h1, 4'h0, 4'h4, 4'h0);
        chk("wrcr_old_cr", 8'(bus.ctrl_reg), 8'h0);
        tick();
        chk("wrcr_new_cr", 8'(bus.ctrl_reg), 8'h1);

        // Mode 01: wr=4, wc counts up 0..4
        for (int i = 0; i < 4; i++) begin
            drive(I_ENCT, 1'b1, 4'h0, W'(i), 4'h4, 4'h0);
            chk("m01_strb", 8'({bus.enw, bus.incw, bus.ena}), 8'b111);
            tick();
            chk("m01_done", 8'(bus.done), (i == 3) ? 8'h1 : 8'h0);
        end

        // Mode 10 with decrementing address: ac 5->2, wr=2
        drive(I_WRCR, 1'b0, 4'h6, 4'h0, 4'h2, 4'h5);
        tick();
        chk("m10_cr", 8'(bus.ctrl_reg), 8'h6);
        chk("m10_done_clr", 8'(bus.done), 8'h0);
        for (int i = 0; i < 3; i++) begin
            drive(I_ENCT, 1'b1, 4'h0, 4'h7, 4'h2, W'(5 - i));
            chk("m10_strb", 8'({bus.enw, bus.ena, bus.inca, bus.aci}), 8'b0101);
            tick();
            chk("m10_done", 8'(bus.done), (i == 2) ? 8'h1 : 8'h0);
        end

        // Mode 11 never terminates; cin=0 gives no count
        drive(I_WRCR, 1'b0, 4'h3, 4'h1, 4'h2, 4'h1);
        tick();
        drive(I_ENCT, 1'b1, 4'h0, 4'h1, 4'h2, 4'h1);
        chk("m11_enw", 8'(bus.enw), 8'h1);
        tick();
        chk("m11_done", 8'(bus.done), 8'h0);
        drive(I_ENCT, 1'b0, 4'h0, 4'h0, 4'h2, 4'h0);
        chk("cin0_strb", 8'({bus.enw, bus.ena, bus.wci, bus.aci}), 8'b0000);
        tick();
        drive(I_RDCR, 1'b0, 4'h0, 4'h0, 4'h2, 4'h0);
        tick();
        chk("rdcr_data", 8'(bus.data_out), 8'h3);

        // Mode 01 with wr=0 terminates at wc=F
        drive(I_WRCR, 1'b0, 4'h1, 4'h0, 4'h0, 4'h0);
        tick();
        drive(I_ENCT, 1'b1, 4'h0, 4'hE, 4'h0, 4'h0);
        tick();
        chk("wr0_e_done", 8'(bus.done), 8'h0);
        drive(I_ENCT, 1'b1, 4'h0, 4'hF, 4'h0, 4'h0);
        tick();
        chk("wr0_f_done", 8'(bus.done), 8'h1);

        // Reset during RUN kills strobes immediately
        drive(I_REINIT, 1'b0, 4'h0, 4'h3, 4'h0, 4'h0);
        tick();
        drive(I_ENCT, 1'b1, 4'h0, 4'h3, 4'h0, 4'h0);
        tick();
        drive(I_ENCT, 1'b1, 4'h0, 4'h4, 4'h0, 4'h0);
        chk("run_enw", 8'(bus.enw), 8'h1);
        res_n = 1'b0;
        #1;
        chk("midrst_strb", 8'({bus.enw, bus.ena, bus.wci, bus.aci, bus.incw}), 8'h0);
        @(negedge clk);
        res_n = 1'b1;
        #1;
        chk("post_rst_done", 8'(bus.done), 8'h0);
        chk("post_rst_cr", 8'(bus.ctrl_reg), 8'h0);
        drive(I_ENCT, 1'b1, 4'h0, 4'h4, 4'h0, 4'h0);
        chk("post_rst_idle", 8'({bus.enw, bus.ena}), 8'h0);
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
